// File: rtl/salaga_pkg.sv
// salaga_soc shared definitions: opcodes, funct3 codes, ALU ops,
// decode bundle and the helper ALU used by the core.
package salaga_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] HALT_INST = 32'h0000_0000;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

    typedef enum logic {ST_RUN, ST_HALT} core_state_t;

    typedef struct packed {
        logic        legal;
        logic        rd_we;
        logic        ld;
        logic        st;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        a_pc;
        logic        b_imm;
        alu_op_t     alu_op;
        wb_sel_t     wb;
        logic [31:0] imm;
    } ctrl_t;

    function automatic alu_op_t alu_sel(logic [2:0] f3, logic alt);
        alu_op_t op;
        unique case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu(alu_op_t op, logic [31:0] a,
                                        logic [31:0] b);
        logic [31:0] y;
        unique case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << b[4:0];
            ALU_SLT:   y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  y = {31'b0, a < b};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> b[4:0];
            ALU_SRA:   y = $signed(a) >>> b[4:0];
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/salaga_if.sv
// salaga_soc word memory bus: combinational read, byte-strobed write.
interface salaga_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;

    modport master (output addr, output wdata, output wstrb,
                    input rdata);
    modport slave (input addr, input wdata, input wstrb,
                   output rdata);
endinterface

// File: rtl/salaga_soc_core.sv
// salaga_soc single-cycle RV32I core; SALAGA_BYTE_LS_EN adds
// LB/LH/LBU/LHU/SB/SH, otherwise those encodings are NOPs.
module salaga_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     reset,
    salaga_if.master ibus,
    salaga_if.master dbus
);
    import salaga_pkg::*;

    core_state_t state;
    ctrl_t       c;

    logic [31:0] pc, pc4, inst;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, op_a, op_b, alu_y;
    logic [31:0] addr, ld_val, st_data, rd_val;
    logic [31:0] jump_pc, next_pc;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  st_strb;
    logic        ld_ok, st_ok, taken, halt_now, run;

    assign inst = ibus.rdata;
    assign {f7, rs2, rs1, f3, rd, opcode} = inst;

    assign ibus.addr  = pc;
    assign ibus.wdata = '0;
    assign ibus.wstrb = '0;

    assign pc4   = pc + 32'd4;
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    always_comb begin
        c        = '0;
        c.alu_op = ALU_ADD;
        c.wb     = WB_ALU;
        unique case (1'b1)
            opcode == OP_LUI: begin
                c.legal  = 1'b1;
                c.rd_we  = 1'b1;
                c.b_imm  = 1'b1;
                c.imm    = imm_u;
                c.alu_op = ALU_PASSB;
            end
            opcode == OP_AUIPC: begin
                c.legal = 1'b1;
                c.rd_we = 1'b1;
                c.a_pc  = 1'b1;
                c.b_imm = 1'b1;
                c.imm   = imm_u;
            end
            opcode == OP_JAL: begin
                c.legal = 1'b1;
                c.rd_we = 1'b1;
                c.jal   = 1'b1;
                c.wb    = WB_PC4;
                c.imm   = imm_j;
            end
            opcode == OP_JALR: begin
                c.legal = (f3 == 3'b000);
                c.rd_we = 1'b1;
                c.jalr  = 1'b1;
                c.wb    = WB_PC4;
                c.b_imm = 1'b1;
                c.imm   = imm_i;
            end
            opcode == OP_BRANCH: begin
                c.legal = (f3 != 3'b010) && (f3 != 3'b011);
                c.br    = 1'b1;
                c.imm   = imm_b;
            end
            opcode == OP_LOAD: begin
                c.legal = ld_ok;
                c.rd_we = 1'b1;
                c.ld    = 1'b1;
                c.wb    = WB_MEM;
                c.b_imm = 1'b1;
                c.imm   = imm_i;
            end
            opcode == OP_STORE: begin
                c.legal = st_ok;
                c.st    = 1'b1;
                c.b_imm = 1'b1;
                c.imm   = imm_s;
            end
            opcode == OP_IMM: begin
                if (f3 == F3_SLL) begin
                    c.legal = (f7 == 7'h00);
                end else if (f3 == F3_SR) begin
                    c.legal = (f7 == 7'h00) || (f7 == 7'h20);
                end else begin
                    c.legal = 1'b1;
                end
                c.rd_we  = 1'b1;
                c.b_imm  = 1'b1;
                c.imm    = imm_i;
                c.alu_op = alu_sel(f3, (f3 == F3_SR) && f7[5]);
            end
            opcode == OP_REG: begin
                c.legal  = (f7 == 7'h00) ||
                           ((f7 == 7'h20) &&
                            ((f3 == F3_ADD) || (f3 == F3_SR)));
                c.rd_we  = 1'b1;
                c.alu_op = alu_sel(f3, f7[5]);
            end
            default: begin
            end
        endcase
    end

    assign op_a  = c.a_pc ? pc : rs1_val;
    assign op_b  = c.b_imm ? c.imm : rs2_val;
    assign alu_y = alu(c.alu_op, op_a, op_b);
    assign addr  = alu_y;

    always_comb begin
        taken = 1'b0;
        unique case (f3)
            F3_BEQ:  taken = (rs1_val == rs2_val);
            F3_BNE:  taken = (rs1_val != rs2_val);
            F3_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: taken = (rs1_val < rs2_val);
            F3_BGEU: taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

`ifdef SALAGA_BYTE_LS_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = dbus.rdata[{addr[1:0], 3'b000} +: 8];
    assign ld_half = addr[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
    assign ld_ok   = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                     (f3 == F3_BU) || (f3 == F3_HU);
    assign st_ok   = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);

    always_comb begin
        ld_val  = dbus.rdata;
        st_data = rs2_val;
        st_strb = 4'hf;
        unique case (f3)
            F3_B:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_val = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_val = {24'b0, ld_byte};
            F3_HU:   ld_val = {16'b0, ld_half};
            default: ld_val = dbus.rdata;
        endcase
        // Replicate the lane so strobes alone select the target bytes.
        unique case (f3)
            F3_B: begin
                st_data = {4{rs2_val[7:0]}};
                st_strb = 4'b0001 << addr[1:0];
            end
            F3_H: begin
                st_data = {2{rs2_val[15:0]}};
                st_strb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = rs2_val;
                st_strb = 4'hf;
            end
        endcase
    end
`else
    assign ld_ok   = (f3 == F3_W);
    assign st_ok   = (f3 == F3_W);
    assign ld_val  = dbus.rdata;
    assign st_data = rs2_val;
    assign st_strb = 4'hf;
`endif

    always_comb begin
        unique case (c.wb)
            WB_MEM:  rd_val = ld_val;
            WB_PC4:  rd_val = pc4;
            default: rd_val = alu_y;
        endcase
    end

    assign jump_pc = c.jalr ? {alu_y[31:1], 1'b0} : pc + c.imm;
    assign next_pc = (c.legal && (c.jal || c.jalr || (c.br && taken)))
                   ? jump_pc : pc4;

    // Nothing retires on a halt fetch, while halted, or in reset.
    assign halt_now = (inst == HALT_INST) || (state == ST_HALT);
    assign run      = !reset && !halt_now && c.legal;

    assign dbus.addr  = addr;
    assign dbus.wdata = st_data;
    assign dbus.wstrb = (run && c.st) ? st_strb : 4'b0000;

    salaga_regfile register_file_0 (
        .clk   (clk),
        .reset (reset),
        .ra    (rs1),
        .rb    (rs2),
        .wa    (rd),
        .we    (run && c.rd_we),
        .wd    (rd_val),
        .qa    (rs1_val),
        .qb    (rs2_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= ST_RUN;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (inst == HALT_INST) begin
                        state <= ST_HALT;
                    end else begin
                        pc <= next_pc;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RUN;
            endcase
        end
    end
endmodule

// File: rtl/salaga_soc_mem.sv
// salaga_soc word memory: combinational read, posedge byte-lane
// writes, upper address bits ignored so accesses wrap.
module salaga_mem #(
    parameter int DEPTH = 256
) (
    input logic     clk,
    salaga_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    bit [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic          unused_addr;

    assign idx         = bus.addr[AW+1:2];
    assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};
    assign bus.rdata   = mem[idx];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.wstrb[i]) begin
                mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/salaga_soc_regfile.sv
// salaga_soc register file: 32 x 32, two async reads, one posedge
// write; x0 reads zero, reads during a write see the old value.
module salaga_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra,
    input  logic [4:0]  rb,
    input  logic [4:0]  wa,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] qa,
    output logic [31:0] qb
);
    logic [31:0] mem [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wa != 5'd0) begin
            mem[wa] <= wd;
        end
    end

    assign qa = (ra == 5'd0) ? 32'd0 : mem[ra];
    assign qb = (rb == 5'd0) ? 32'd0 : mem[rb];
endmodule

// File: rtl/salaga_soc.sv
// salaga_soc top: RV32I core with separate instruction and data
// word memories on one clock.
module salaga_soc #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic reset
);
    salaga_if imem_bus ();
    salaga_if dmem_bus ();

    logic [31:0] inst_from_imem;

    assign inst_from_imem = imem_bus.rdata;

    salaga_core #(
        .RESET_PC (RESET_PC)
    ) processor_0 (
        .clk   (clk),
        .reset (reset),
        .ibus  (imem_bus),
        .dbus  (dmem_bus)
    );

    salaga_mem #(
        .DEPTH (IMEM_DEPTH)
    ) imem_0 (
        .clk (clk),
        .bus (imem_bus)
    );

    salaga_mem #(
        .DEPTH (DMEM_DEPTH)
    ) dmem_0 (
        .clk (clk),
        .bus (dmem_bus)
    );
endmodule

// File: tb/tb_salaga_soc.sv
// Bench for salaga_soc: directed programs plus random programs
// compared against an instruction-level reference interpreter.
module tb_salaga_soc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    salaga_soc dut (.clk(clk), .reset(reset));

    salaga_if probe ();
    assign probe.addr  = dut.processor_0.pc;
    assign probe.rdata = dut.inst_from_imem;
    assign probe.wdata = 32'h0;
    assign probe.wstrb = 4'h0;

    logic [31:0] prog [$];
    logic [31:0] mim [256];
    logic [31:0] mdm [256];
    logic [31:0] mr [32];
    logic [31:0] mpc;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rx(int i);
        return dut.processor_0.register_file_0.mem[i];
    endfunction

    function automatic logic [31:0] dm(int i);
        return dut.dmem_0.mem[i];
    endfunction

    function automatic logic [31:0] i_t(logic [11:0] imm, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd,
                                        logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] rs2,
                                        logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] s_t(logic [11:0] imm, logic [4:0] rs2,
                                        logic [4:0] rs1, logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] b_t(logic [12:0] imm, logic [4:0] rs2,
                                        logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] u_t(logic [19:0] imm, logic [4:0] rd,
                                        logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] j_t(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = (i < prog.size()) ? prog[i] : 32'h0;
            dut.imem_0.mem[i] <= w;
            dut.dmem_0.mem[i] <= 32'h0;
            mim[i] = w;
            mdm[i] = 32'h0;
        end
    endtask

    task automatic start();
        reset = 1'b1;
        load_prog();
        cyc(2);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] m_alu(logic [2:0] f3, logic [31:0] a,
                                          logic [31:0] b, logic alt);
        logic [31:0] y;
        int sh;
        sh = b % 32;
        case (f3)
            3'd0: y = alt ? a - b : a + b;
            3'd1: y = a << sh;
            3'd2: y = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd3: y = (a < b) ? 1 : 0;
            3'd4: y = a ^ b;
            3'd5: begin
                if (alt) y = $signed(a) >>> sh;
                else y = a >> sh;
            end
            3'd6: y = a | b;
            default: y = a & b;
        endcase
        return y;
    endfunction

    task automatic model_run(output int steps);
        logic [31:0] in, a, b, res, npc, ea, si, ss, sb, sj;
        logic [2:0] f3;
        logic take, wr;
        steps = 0;
        mpc = 32'h0;
        for (int i = 0; i < 32; i++) mr[i] = 32'h0;
        while (steps < 500) begin
            in = mim[(mpc / 4) % 256];
            if (in == 32'h0) break;
            steps++;
            f3 = in[14:12];
            a = mr[in[19:15]];
            b = mr[in[24:20]];
            si = $signed(in[31:20]);
            ss = $signed({in[31:25], in[11:7]});
            sb = $signed({in[31], in[7], in[30:25], in[11:8], 1'b0});
            sj = $signed({in[31], in[19:12], in[20], in[30:21], 1'b0});
            wr = 1'b0;
            res = 32'h0;
            npc = mpc + 4;
            case (in[6:0])
                7'h37: begin wr = 1; res = {in[31:12], 12'h0}; end
                7'h17: begin wr = 1; res = mpc + {in[31:12], 12'h0}; end
                7'h6f: begin wr = 1; res = mpc + 4; npc = mpc + sj; end
                7'h67: begin
                    wr = 1;
                    res = mpc + 4;
                    npc = (a + si) & 32'hffff_fffe;
                end
                7'h63: begin
                    case (f3)
                        3'd0: take = (a == b);
                        3'd1: take = (a != b);
                        3'd4: take = ($signed(a) < $signed(b));
                        3'd5: take = ($signed(a) >= $signed(b));
                        3'd6: take = (a < b);
                        default: take = (a >= b);
                    endcase
                    if (take) npc = mpc + sb;
                end
                7'h03: begin
                    ea = a + si;
                    wr = 1;
                    res = mdm[(ea / 4) % 256];
                end
                7'h23: begin
                    ea = a + ss;
                    mdm[(ea / 4) % 256] = b;
                end
                7'h13: res = m_alu(f3, a, si, (f3 == 3'd5) && in[30]);
                7'h33: res = m_alu(f3, a, b, in[30]);
                default: ;
            endcase
            if (in[6:0] == 7'h13 || in[6:0] == 7'h33) wr = 1;
            if (wr && in[11:7] != 0) mr[in[11:7]] = res;
            mpc = npc;
        end
    endtask

    task automatic gen_random();
        logic [2:0] bf3 [6];
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        prog.delete();
        for (int i = 1; i < 8; i++)
            prog.push_back(i_t(12'($urandom), 5'd0, 3'd0, 5'(i), 7'h13));
        for (int k = 0; k < 40; k++) begin
            int kind;
            logic [4:0] rd, rs1, rs2, sh;
            logic [2:0] f3;
            logic [11:0] imm;
            logic alt;
            kind = $urandom_range(0, 7);
            rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            f3 = 3'($urandom);
            sh = 5'($urandom);
            alt = 1'($urandom);
            imm = 12'($urandom);
            case (kind)
                0, 1: prog.push_back(r_t(
                          ((f3 == 0 || f3 == 5) && alt) ? 7'h20 : 7'h00,
                          rs2, rs1, f3, rd));
                2, 3: begin
                    if (f3 == 3'd1) imm = {7'h00, sh};
                    if (f3 == 3'd5) imm = {alt ? 7'h20 : 7'h00, sh};
                    prog.push_back(i_t(imm, rs1, f3, rd, 7'h13));
                end
                4: prog.push_back(u_t(20'($urandom), rd,
                                      alt ? 7'h37 : 7'h17));
                5: begin
                    imm = 12'($urandom_range(0, 31));
                    if (alt) prog.push_back(i_t(imm, 5'd0, 3'd2, rd, 7'h03));
                    else prog.push_back(s_t(imm, rs2, 5'd0, 3'd2));
                end
                6: prog.push_back(b_t(13'd8, rs2, rs1,
                                      bf3[$urandom_range(0, 5)]));
                default: prog.push_back(32'hffff_ffff);
            endcase
        end
        prog.push_back(32'h0);
    endtask

    initial begin
        int steps;
        logic [31:0] w;

        // Arithmetic and halt timing
        prog = '{i_t(12'd5, 5'd0, 3'd0, 5'd1, 7'h13),
                 i_t(12'd7, 5'd0, 3'd0, 5'd2, 7'h13),
                 r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),
                 r_t(7'h20, 5'd2, 5'd1, 3'd0, 5'd4),
                 s_t(12'd0, 5'd3, 5'd0, 3'd2),
                 s_t(12'd4, 5'd4, 5'd0, 3'd2),
                 32'h0};
        start();
        chk("reset_pc", probe.addr, 32'h0);
        chk("reset_inst", probe.rdata, prog[0]);
        for (int i = 1; i < 32; i++)
            chk($sformatf("reset_x%0d", i), rx(i), 32'h0);
        cyc(5);
        chk("arith_pc5", probe.addr, 32'h14);
        cyc(1);
        chk("arith_pc6", probe.addr, 32'h18);
        chk("arith_inst_halt", probe.rdata, 32'h0);
        chk("arith_x3", rx(3), 32'h0000000c);
        chk("arith_x4", rx(4), 32'hfffffffe);
        chk("arith_m0", dm(0), 32'h0000000c);
        chk("arith_m1", dm(1), 32'hfffffffe);
        cyc(5);
        chk("halt_pc", probe.addr, 32'h18);
        chk("halt_x3", rx(3), 32'h0000000c);
        chk("halt_m1", dm(1), 32'hfffffffe);
        chk("halt_m2", dm(2), 32'h0);

        // Load/store, then an illegal word executes as a NOP
        prog = '{i_t(12'd8, 5'd0, 3'd2, 5'd5, 7'h03),
                 i_t(12'd1, 5'd5, 3'd0, 5'd5, 7'h13),
                 s_t(12'd12, 5'd5, 5'd0, 3'd2),
                 32'hffff_ffff,
                 32'h0};
        reset = 1'b1;
        load_prog();
        dut.dmem_0.mem[2] <= 32'hdeadbeef;
        cyc(2);
        reset = 1'b0;
        cyc(6);
        chk("ls_x5", rx(5), 32'hdeadbef0);
        chk("ls_m3", dm(3), 32'hdeadbef0);
        chk("ls_m2", dm(2), 32'hdeadbeef);
        chk("ls_m0", dm(0), 32'h0);
        chk("ls_m4", dm(4), 32'h0);
        chk("ls_pc", probe.addr, 32'h10);

        // Branch loop and mid-program reset
        prog = '{i_t(12'd3, 5'd0, 3'd0, 5'd1, 7'h13),
                 i_t(12'd2, 5'd2, 3'd0, 5'd2, 7'h13),
                 i_t(12'hfff, 5'd1, 3'd0, 5'd1, 7'h13),
                 b_t(13'h1ff8, 5'd0, 5'd1, 3'd1),
                 32'h0};
        reset = 1'b1;
        load_prog();
        dut.dmem_0.mem[5] <= 32'hcafef00d;
        cyc(2);
        reset = 1'b0;
        cyc(20);
        chk("loop_x2", rx(2), 32'h6);
        chk("loop_x1", rx(1), 32'h0);
        chk("loop_pc", probe.addr, 32'h10);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(5);
        chk("mid_pc_running", probe.addr, 32'h8);
        reset = 1'b1;
        cyc(2);
        chk("mid_rst_pc", probe.addr, 32'h0);
        chk("mid_rst_x1", rx(1), 32'h0);
        chk("mid_rst_x2", rx(2), 32'h0);
        chk("mid_rst_m5", dm(5), 32'hcafef00d);
        reset = 1'b0;
        cyc(20);
        chk("rerun_x2", rx(2), 32'h6);
        chk("rerun_x1", rx(1), 32'h0);
        chk("rerun_m5", dm(5), 32'hcafef00d);

        // Jumps, upper immediates, x0
        prog = '{j_t(21'd8, 5'd1),
                 i_t(12'd1, 5'd0, 3'd0, 5'd7, 7'h13),
                 u_t(20'h12345, 5'd6, 7'h37),
                 i_t(12'd9, 5'd0, 3'd0, 5'd0, 7'h13),
                 u_t(20'h00001, 5'd8, 7'h17),
                 i_t(12'h01d, 5'd0, 3'd0, 5'd9, 7'h67),
                 i_t(12'd2, 5'd0, 3'd0, 5'd7, 7'h13),
                 32'h0};
        start();
        cyc(8);
        chk("jal_x1", rx(1), 32'h4);
        chk("jal_skip_x7", rx(7), 32'h0);
        chk("lui_x6", rx(6), 32'h12345000);
        chk("x0_zero", rx(0), 32'h0);
        chk("auipc_x8", rx(8), 32'h00001010);
        chk("jalr_x9", rx(9), 32'h18);
        chk("jalr_pc", probe.addr, 32'h1c);

        // Sub-word accesses
        prog = '{i_t(12'h0aa, 5'd0, 3'd0, 5'd1, 7'h13),
                 s_t(12'd1, 5'd1, 5'd0, 3'd0),
                 i_t(12'd1, 5'd0, 3'd0, 5'd2, 7'h03),
                 i_t(12'd1, 5'd0, 3'd4, 5'd3, 7'h03),
                 32'h0};
        reset = 1'b1;
        load_prog();
        dut.dmem_0.mem[0] <= 32'h11223344;
        cyc(2);
        reset = 1'b0;
        cyc(6);
        chk("byte_x1", rx(1), 32'haa);
`ifdef SALAGA_BYTE_LS_EN
        chk("sb_m0", dm(0), 32'h1122aa44);
        chk("lb_x2", rx(2), 32'hffffffaa);
        chk("lbu_x3", rx(3), 32'h000000aa);
`else
        chk("sb_nop_m0", dm(0), 32'h11223344);
        chk("lb_nop_x2", rx(2), 32'h0);
        chk("lbu_nop_x3", rx(3), 32'h0);
`endif

        // Random programs against the reference interpreter
        for (int t = 0; t < 4; t++) begin
            gen_random();
            reset = 1'b1;
            load_prog();
            for (int i = 0; i < 8; i++) begin
                w = $urandom;
                dut.dmem_0.mem[i] <= w;
                mdm[i] = w;
            end
            cyc(2);
            reset = 1'b0;
            model_run(steps);
            cyc(steps + 3);
            chk($sformatf("rnd%0d_pc", t), probe.addr, mpc);
            for (int i = 1; i < 32; i++)
                chk($sformatf("rnd%0d_x%0d", t, i), rx(i), mr[i]);
            for (int i = 0; i < 8; i++)
                chk($sformatf("rnd%0d_m%0d", t, i), dm(i), mdm[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
